wb_excp_commit: RTL and testbench

- Writeback/commit stage of the LoongArch pipeline, directly upstream of the CSR file.
- Registers one instruction from MEM and resolves its exception, interrupt or ERTN status.
- Drives the CSR file's exception inputs (excp_flush, ertn_flush, ecode, esubcode, era_pc, error_badv_we, badv_wdata) and its CSR write port, plus register-file writeback and the fetch redirect.
- After any flush, it discards in-flight upstream beats for a fixed drain window.

---
 rtl/wb_excp_commit.sv | 160 ++++++++++++++++
 tb/tb_wb_excp_commit.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_excp_commit.sv
// Writeback / commit stage: registers one instruction from MEM, resolves
// exception, interrupt and ERTN status for the CSR file, performs the CSR
// and register-file writes, and drains upstream beats after every flush.
module wb_excp_commit #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ms_valid,
  output logic        ws_allowin,
  input  logic [31:0] ms_pc,
  input  logic [4:0]  ms_excp,
  input  logic [31:0] ms_badv,
  input  logic        ms_is_ertn,
  input  logic [1:0]  ms_csr_op,
  input  logic [13:0] ms_csr_num,
  input  logic [31:0] ms_csr_wval,
  input  logic [31:0] ms_csr_mask,
  input  logic        ms_rf_we,
  input  logic [4:0]  ms_rf_waddr,
  input  logic [31:0] ms_rf_wdata,
  input  logic        has_int,
  input  logic [31:0] excp_pc,
  input  logic [31:0] ertn_pc,
  input  logic [31:0] csr_rdata,
  output logic [13:0] csr_raddr,
  output logic        csr_we,
  output logic [13:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        excp_flush,
  output logic        ertn_flush,
  output logic [5:0]  ecode,
  output logic [8:0]  esubcode,
  output logic [31:0] era_pc,
  output logic        error_badv_we,
  output logic [31:0] badv_wdata,
  output logic        flush,
  output logic [31:0] flush_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] debug_wb_pc,
  output logic [31:0] inst_retired
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          ws_valid;
  logic [31:0]   ws_pc;
  logic [4:0]    ws_excp;
  logic [31:0]   ws_badv;
  logic          ws_is_ertn;
  logic [1:0]    ws_csr_op;
  logic [13:0]   ws_csr_num;
  logic [31:0]   ws_csr_wval;
  logic [31:0]   ws_csr_mask;
  logic          ws_rf_we;
  logic [4:0]    ws_rf_waddr;
  logic [31:0]   ws_rf_wdata;

  // Every instruction spends exactly one cycle here, so WB is always ready.
  assign ws_allowin = 1'b1;

  // Pipeline register, drain window control and retirement counter.
  // A flush always (re)starts the drain window; the beat presented on the
  // flush edge itself is expected to be cancelled by the upstream stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      drain_cnt    <= '0;
      ws_valid     <= 1'b0;
      ws_pc        <= '0;
      ws_excp      <= '0;
      ws_badv      <= '0;
      ws_is_ertn   <= 1'b0;
      ws_csr_op    <= '0;
      ws_csr_num   <= '0;
      ws_csr_wval  <= '0;
      ws_csr_mask  <= '0;
      ws_rf_we     <= 1'b0;
      ws_rf_waddr  <= '0;
      ws_rf_wdata  <= '0;
      inst_retired <= '0;
    end else begin
      if (ws_valid && !excp_flush)
        inst_retired <= inst_retired + 32'd1;

      if (flush) begin
        state     <= DRAIN;
        drain_cnt <= CW'(DRAIN_CYCLES - 1);
      end else if (state == DRAIN) begin
        if (drain_cnt == '0)
          state <= RUN;
        else
          drain_cnt <= drain_cnt - CW'(1);
      end

      if (state == RUN && ms_valid && ws_allowin) begin
        ws_valid    <= 1'b1;
        ws_pc       <= ms_pc;
        ws_excp     <= ms_excp;
        ws_badv     <= ms_badv;
        ws_is_ertn  <= ms_is_ertn;
        ws_csr_op   <= ms_csr_op;
        ws_csr_num  <= ms_csr_num;
        ws_csr_wval <= ms_csr_wval;
        ws_csr_mask <= ms_csr_mask;
        ws_rf_we    <= ms_rf_we;
        ws_rf_waddr <= ms_rf_waddr;
        ws_rf_wdata <= ms_rf_wdata;
      end else begin
        ws_valid <= 1'b0;
      end
    end
  end

  assign excp_flush = ws_valid && (has_int || (|ws_excp));
  assign ertn_flush = ws_valid && ws_is_ertn && !excp_flush;
  assign flush      = excp_flush | ertn_flush;

  // Exception code by priority: interrupt, ADEF, INE, SYS, BRK, ALE.
  always_comb begin
    ecode = 6'h00;
    if (excp_flush && !has_int) begin
      if (ws_excp[0])      ecode = 6'h08;
      else if (ws_excp[1]) ecode = 6'h0D;
      else if (ws_excp[2]) ecode = 6'h0B;
      else if (ws_excp[3]) ecode = 6'h0C;
      else if (ws_excp[4]) ecode = 6'h09;
    end
  end

  assign esubcode = 9'd0;
  assign era_pc   = ws_pc;

  // BADV is only written when the winning cause is ADEF or ALE.
  assign error_badv_we = excp_flush && !has_int &&
                         (ws_excp[0] || (ws_excp[4] && !ws_excp[1] && !ws_excp[2] && !ws_excp[3]));
  assign badv_wdata    = ws_excp[0] ? ws_pc : ws_badv;

  assign flush_pc = excp_flush ? excp_pc : (ertn_flush ? ertn_pc : 32'h0);

  // CSR port: csrxchg merges the new value under the mask into the old one.
  assign csr_raddr = ws_csr_num;
  assign csr_waddr = ws_csr_num;
  assign csr_we    = ws_valid && ws_csr_op[1] && !flush;
  assign csr_wdata = (ws_csr_op == 2'd3) ? ((csr_rdata & ~ws_csr_mask) | (ws_csr_wval & ws_csr_mask)) :
                     (ws_csr_op == 2'd2) ? ws_csr_wval : 32'h0;

  // CSR instructions return the old CSR value to rd.
  assign rf_we       = ws_valid && ws_rf_we && !flush;
  assign rf_waddr    = ws_rf_waddr;
  assign rf_wdata    = (ws_csr_op != 2'd0) ? csr_rdata : ws_rf_wdata;
  assign debug_wb_pc = ws_pc;

endmodule

// File: tb/tb_wb_excp_commit.sv
// Bench for wb_excp_commit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_wb_excp_commit;

  localparam int DRAIN = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  excp;
    logic [31:0] badv;
    logic        ertn;
    logic [1:0]  op;
    logic [13:0] num;
    logic [31:0] wval;
    logic [31:0] mask;
    logic        rfwe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } instr_t;

  logic clk = 1'b0;
  logic reset;
  logic ms_valid;
  instr_t cur;
  logic has_int;
  logic [31:0] excp_pc, ertn_pc, csr_rdata;

  logic        ws_allowin, csr_we, excp_flush, ertn_flush, error_badv_we, flush, rf_we;
  logic [13:0] csr_raddr, csr_waddr;
  logic [31:0] csr_wdata, era_pc, badv_wdata, flush_pc, rf_wdata, debug_wb_pc, inst_retired;
  logic [5:0]  ecode;
  logic [8:0]  esubcode;
  logic [4:0]  rf_waddr;

  logic [31:0] ms_pc, ms_badv, ms_csr_wval, ms_csr_mask, ms_rf_wdata;
  logic [4:0]  ms_excp, ms_rf_waddr;
  logic        ms_is_ertn, ms_rf_we;
  logic [1:0]  ms_csr_op;
  logic [13:0] ms_csr_num;

  assign ms_pc       = cur.pc;
  assign ms_excp     = cur.excp;
  assign ms_badv     = cur.badv;
  assign ms_is_ertn  = cur.ertn;
  assign ms_csr_op   = cur.op;
  assign ms_csr_num  = cur.num;
  assign ms_csr_wval = cur.wval;
  assign ms_csr_mask = cur.mask;
  assign ms_rf_we    = cur.rfwe;
  assign ms_rf_waddr = cur.waddr;
  assign ms_rf_wdata = cur.wdata;

  always #5 clk = ~clk;

  wb_excp_commit #(.DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
    .ms_pc(ms_pc), .ms_excp(ms_excp), .ms_badv(ms_badv), .ms_is_ertn(ms_is_ertn),
    .ms_csr_op(ms_csr_op), .ms_csr_num(ms_csr_num), .ms_csr_wval(ms_csr_wval),
    .ms_csr_mask(ms_csr_mask), .ms_rf_we(ms_rf_we), .ms_rf_waddr(ms_rf_waddr),
    .ms_rf_wdata(ms_rf_wdata), .has_int(has_int), .excp_pc(excp_pc), .ertn_pc(ertn_pc),
    .csr_rdata(csr_rdata), .csr_raddr(csr_raddr), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .ecode(ecode), .esubcode(esubcode), .era_pc(era_pc), .error_badv_we(error_badv_we),
    .badv_wdata(badv_wdata), .flush(flush), .flush_pc(flush_pc), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc),
    .inst_retired(inst_retired)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Holds the instruction last accepted into WB, how many more upstream
  // beats must be thrown away, and the retirement count.
  bit          m_valid;
  instr_t      m;
  int          drop_left;
  logic [31:0] m_ret;

  function automatic bit m_exc();
    return m_valid && (has_int || m.excp != 5'd0);
  endfunction

  function automatic bit m_flush();
    return m_exc() || (m_valid && m.ertn);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_valid   = 1'b0;
      m         = '0;
      drop_left = 0;
      m_ret     = 32'd0;
    end else begin
      bit fl;
      fl = m_flush();
      if (m_valid && !m_exc()) m_ret = m_ret + 32'd1;
      if (drop_left > 0) begin
        m_valid = 1'b0;
        drop_left--;
      end else if (ms_valid) begin
        m_valid = 1'b1;
        m       = cur;
      end else begin
        m_valid = 1'b0;
      end
      if (fl) drop_left = DRAIN;
    end
  end

  // Compare every DUT output against the model, away from the clock edge.
  always @(negedge clk) begin
    if (chk_en) begin
      bit exc, ert, bwe;
      logic [5:0]  code;
      logic [31:0] fpc, cwd, rwd;
      exc = m_exc();
      ert = m_valid && m.ertn && !exc;
      code = 6'h00;
      if (exc && !has_int) begin
        if (m.excp[0])      code = 6'h08;
        else if (m.excp[1]) code = 6'h0D;
        else if (m.excp[2]) code = 6'h0B;
        else if (m.excp[3]) code = 6'h0C;
        else                code = 6'h09;
      end
      bwe = exc && !has_int && (code == 6'h08 || code == 6'h09);
      fpc = exc ? excp_pc : (ert ? ertn_pc : 32'h0);
      case (m.op)
        2'd2:    cwd = m.wval;
        2'd3:    cwd = (csr_rdata & ~m.mask) | (m.wval & m.mask);
        default: cwd = 32'h0;
      endcase
      rwd = (m.op != 2'd0) ? csr_rdata : m.wdata;
      chk("ws_allowin", 32'(ws_allowin), 32'd1);
      chk("excp_flush", 32'(excp_flush), 32'(exc));
      chk("ertn_flush", 32'(ertn_flush), 32'(ert));
      chk("flush", 32'(flush), 32'(exc || ert));
      chk("ecode", 32'(ecode), 32'(code));
      chk("esubcode", 32'(esubcode), 32'd0);
      chk("era_pc", era_pc, m.pc);
      chk("error_badv_we", 32'(error_badv_we), 32'(bwe));
      if (bwe) chk("badv_wdata", badv_wdata, m.excp[0] ? m.pc : m.badv);
      chk("flush_pc", flush_pc, fpc);
      chk("csr_raddr", 32'(csr_raddr), 32'(m.num));
      chk("csr_waddr", 32'(csr_waddr), 32'(m.num));
      chk("csr_we", 32'(csr_we), 32'(m_valid && m.op >= 2'd2 && !(exc || ert)));
      chk("csr_wdata", csr_wdata, cwd);
      chk("rf_we", 32'(rf_we), 32'(m_valid && m.rfwe && !(exc || ert)));
      chk("rf_waddr", 32'(rf_waddr), 32'(m.waddr));
      chk("rf_wdata", rf_wdata, rwd);
      chk("debug_wb_pc", debug_wb_pc, m.pc);
      chk("inst_retired", inst_retired, m_ret);
    end
  end

  // ---------------- stimulus ----------------
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ms_valid = 1'b0;
    repeat (n) edge1();
  endtask

  // Present one instruction for one edge, then hold MEM empty.
  task automatic issue(input instr_t ins);
    cur      = ins;
    ms_valid = 1'b1;
    edge1();
    ms_valid = 1'b0;
  endtask

  function automatic instr_t mk(input logic [31:0] pc, input logic [4:0] excp);
    instr_t t;
    t      = '0;
    t.pc   = pc;
    t.excp = excp;
    return t;
  endfunction

  initial begin
    instr_t t;
    logic [31:0] ret0;
    reset = 1'b1; ms_valid = 1'b0; cur = '0; has_int = 1'b0;
    excp_pc = 32'h1c008000; ertn_pc = 32'h1c004000; csr_rdata = 32'h0;
    edge1();
    chk_en = 1'b1;
    edge1();
    reset = 1'b0;
    @(negedge clk);
    chk("reset excp_flush", 32'(excp_flush), 32'd0);
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset inst_retired", inst_retired, 32'd0);
    chk("reset flush_pc", flush_pc, 32'd0);

    // Normal retire
    t = mk(32'h1c000000, 5'd0); t.rfwe = 1'b1; t.waddr = 5'd5; t.wdata = 32'h1234;
    issue(t);
    @(negedge clk);
    chk("retire rf_we", 32'(rf_we), 32'd1);
    chk("retire rf_wdata", rf_wdata, 32'h1234);
    chk("retire flush", 32'(flush), 32'd0);
    edge1();
    chk("retire count", inst_retired, 32'd1);

    // SYS, then drain window: two dropped beats, third captured
    t = mk(32'h1c000010, 5'h04); t.rfwe = 1'b1; t.op = 2'd2;
    issue(t);
    @(negedge clk);
    chk("sys excp_flush", 32'(excp_flush), 32'd1);
    chk("sys ecode", 32'(ecode), 32'h0B);
    chk("sys era_pc", era_pc, 32'h1c000010);
    chk("sys flush_pc", flush_pc, 32'h1c008000);
    chk("sys rf_we", 32'(rf_we), 32'd0);
    chk("sys csr_we", 32'(csr_we), 32'd0);
    edge1();
    t = mk(32'h1c000100, 5'd0); t.rfwe = 1'b1; issue(t);
    @(negedge clk); chk("drain1 rf_we", 32'(rf_we), 32'd0);
    t = mk(32'h1c000104, 5'd0); t.rfwe = 1'b1; issue(t);
    @(negedge clk); chk("drain2 rf_we", 32'(rf_we), 32'd0);
    chk("drain2 pc", debug_wb_pc, 32'h1c000010);
    t = mk(32'h1c000108, 5'd0); t.rfwe = 1'b1; issue(t);
    @(negedge clk); chk("drain3 rf_we", 32'(rf_we), 32'd1);
    chk("drain3 pc", debug_wb_pc, 32'h1c000108);
    idle(1);

    // Priority: interrupt over everything
    has_int = 1'b1;
    issue(mk(32'h1c000200, 5'h13));
    @(negedge clk);
    chk("int ecode", 32'(ecode), 32'h00);
    chk("int badv_we", 32'(error_badv_we), 32'd0);
    chk("int excp_flush", 32'(excp_flush), 32'd1);
    has_int = 1'b0;
    idle(3);
    issue(mk(32'h1c000204, 5'h13));
    @(negedge clk);
    chk("adef ecode", 32'(ecode), 32'h08);
    chk("adef badv_we", 32'(error_badv_we), 32'd1);
    chk("adef badv", badv_wdata, 32'h1c000204);
    idle(3);

    // ALE
    t = mk(32'h1c000300, 5'h10); t.badv = 32'h800000ab;
    issue(t);
    @(negedge clk);
    chk("ale ecode", 32'(ecode), 32'h09);
    chk("ale badv_we", 32'(error_badv_we), 32'd1);
    chk("ale badv", badv_wdata, 32'h800000ab);
    idle(3);

    // csrxchg
    csr_rdata = 32'hFFFF0000;
    t = mk(32'h1c000400, 5'd0); t.op = 2'd3; t.wval = 32'h00001234; t.mask = 32'h0000FF00;
    t.rfwe = 1'b1; t.num = 14'h0006;
    issue(t);
    @(negedge clk);
    chk("xchg csr_wdata", csr_wdata, 32'hFFFF1200);
    chk("xchg rf_wdata", rf_wdata, 32'hFFFF0000);
    chk("xchg csr_we", 32'(csr_we), 32'd1);
    idle(1);

    // ERTN with INE, then ERTN alone
    t = mk(32'h1c000500, 5'h02); t.ertn = 1'b1;
    issue(t);
    @(negedge clk);
    chk("ertn_ine excp", 32'(excp_flush), 32'd1);
    chk("ertn_ine ertn", 32'(ertn_flush), 32'd0);
    chk("ertn_ine ecode", 32'(ecode), 32'h0D);
    idle(3);
    ret0 = inst_retired;
    t = mk(32'h1c000504, 5'd0); t.ertn = 1'b1;
    issue(t);
    @(negedge clk);
    chk("ertn flush", 32'(ertn_flush), 32'd1);
    chk("ertn excp", 32'(excp_flush), 32'd0);
    chk("ertn flush_pc", flush_pc, 32'h1c004000);
    edge1();
    chk("ertn retired", inst_retired, ret0 + 32'd1);
    idle(2);

    // Reset one cycle after a flush; next beat captured immediately
    issue(mk(32'h1c000600, 5'h04));
    edge1();
    reset = 1'b1;
    edge1();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_drain retired", inst_retired, 32'd0);
    t = mk(32'h1c000700, 5'd0); t.rfwe = 1'b1; t.waddr = 5'd0;
    issue(t);
    @(negedge clk);
    chk("rst_drain pc", debug_wb_pc, 32'h1c000700);
    chk("rst_drain rf_we", 32'(rf_we), 32'd1);
    chk("rst_drain r0", 32'(rf_waddr), 32'd0);
    idle(1);

    // Randomized traffic; upstream cancels its own beat in a flush cycle
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      has_int   = ($urandom_range(0, 15) == 0);
      excp_pc   = $urandom;
      ertn_pc   = $urandom;
      csr_rdata = $urandom;
      t.pc    = $urandom;
      t.excp  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'd0;
      t.badv  = $urandom;
      t.ertn  = ($urandom_range(0, 7) == 0);
      t.op    = 2'($urandom);
      t.num   = 14'($urandom);
      t.wval  = $urandom;
      t.mask  = $urandom;
      t.rfwe  = 1'($urandom);
      t.waddr = 5'($urandom);
      t.wdata = $urandom;
      cur      = t;
      ms_valid = ($urandom_range(0, 3) != 0) && !m_flush();
      edge1();
    end
    reset = 1'b0;
    idle(2);
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
